// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and bundle types for the ID/EX boundary
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 5;
  localparam int CTRL_W = 16;

  // EX/MEM/WB control bundle; the stage treats it as opaque except for
  // zeroing it when a bubble is inserted.
  typedef struct packed {
    logic [6:0] spare;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
  } ctrl_t;

  // Registered ID/EX fields.
  typedef struct packed {
    logic              valid;
    logic [ADR_W-1:0]  rs;
    logic [ADR_W-1:0]  rt;
    logic [ADR_W-1:0]  dest;
    logic              mem_read;
    logic [DATA_W-1:0] imm;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
  } id_ex_t;

endpackage

// File: rtl/hazard_bypass.sv
// rtl/hazard_bypass.sv - write-back bypass of ID operands and load-use detection
module hazard_bypass #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADR_W  = mips_pkg::ADR_W
) (
  input  logic              id_valid_i,
  input  logic [ADR_W-1:0]  id_rs_i,
  input  logic [ADR_W-1:0]  id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [DATA_W-1:0] rf_data1_i,
  input  logic [DATA_W-1:0] rf_data2_i,
  input  logic              wb_reg_write_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [ADR_W-1:0]  ex_dest_i,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o,
  output logic              lu_o
);

  logic rs_hit;
  logic rt_hit;

  // The register file commits on the same edge ID/EX captures, so a write
  // landing this cycle must be forwarded. $0 is not hardwired in the file.
  always_comb begin
    op1_o = (wb_reg_write_i && (wb_adr_i == id_rs_i)) ? wb_data_i : rf_data1_i;
    op2_o = (wb_reg_write_i && (wb_adr_i == id_rt_i)) ? wb_data_i : rf_data2_i;
  end

  // A load in EX cannot feed an instruction in ID without one bubble.
  always_comb begin
    rs_hit = id_uses_rs_i && (id_rs_i == ex_dest_i);
    rt_hit = id_uses_rt_i && (id_rt_i == ex_dest_i);
    lu_o   = id_valid_i && ex_valid_i && ex_mem_read_i && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bypass, load-use stall and flush
module id_ex_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADR_W  = mips_pkg::ADR_W,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADR_W-1:0]  id_rs,
  input  logic [ADR_W-1:0]  id_rt,
  input  logic [ADR_W-1:0]  id_dest,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [ADR_W-1:0]  rf_adr1,
  output logic [ADR_W-1:0]  rf_adr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_reg_write,
  input  logic [ADR_W-1:0]  wb_adr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_hold,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [ADR_W-1:0]  ex_rs,
  output logic [ADR_W-1:0]  ex_rt,
  output logic [ADR_W-1:0]  ex_dest,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  mips_pkg::id_ex_t ex_q, ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [DATA_W-1:0] op1, op2;
  logic lu;

  hazard_bypass #(.DATA_W(DATA_W), .ADR_W(ADR_W)) u_hazard_bypass (
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rs_i   (id_uses_rs),
    .id_uses_rt_i   (id_uses_rt),
    .rf_data1_i     (rf_data1),
    .rf_data2_i     (rf_data2),
    .wb_reg_write_i (wb_reg_write),
    .wb_adr_i       (wb_adr),
    .wb_data_i      (wb_data),
    .ex_valid_i     (ex_q.valid),
    .ex_mem_read_i  (ex_q.mem_read),
    .ex_dest_i      (ex_q.dest),
    .op1_o          (op1),
    .op2_o          (op2),
    .lu_o           (lu)
  );

  assign rf_adr1 = id_rs;
  assign rf_adr2 = id_rt;
  assign stall   = lu || ex_hold;

  assign ex_valid    = ex_q.valid;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_dest     = ex_q.dest;
  assign ex_mem_read = ex_q.mem_read;
  assign ex_imm      = ex_q.imm;
  assign ex_ctrl     = ex_q.ctrl;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign bubble_cnt  = bubble_cnt_q;

  // Next ID/EX contents: flush beats hold, hold beats the load-use bubble,
  // and only then does the decoded instruction advance.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ex_flush) begin
      ex_d.valid = 1'b0;
    end else if (ex_hold) begin
      // Held operands must track write-backs or they go stale while EX is busy.
      if (wb_reg_write && (wb_adr == ex_q.rs)) ex_d.rs_data = wb_data;
      if (wb_reg_write && (wb_adr == ex_q.rt)) ex_d.rt_data = wb_data;
    end else if (lu) begin
      ex_d.valid    = 1'b0;
      ex_d.mem_read = 1'b0;
      ex_d.ctrl     = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.dest     = id_dest;
      ex_d.mem_read = id_mem_read;
      ex_d.imm      = id_imm;
      ex_d.ctrl     = mips_pkg::ctrl_t'(id_ctrl);
      ex_d.rs_data  = op1;
      ex_d.rt_data  = op2;
    end
  end

  // Pipeline register and bubble counter; reset leaves a clean bubble in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary stage sitting directly downstream of the register file.
- Drives the register-file read addresses and samples the two read-data outputs.
- Bypasses a same-cycle write-back into the operands, detects load-use hazards, and holds the ID/EX pipeline register.
- Handles stall, bubble and flush for the rest of the pipeline.

Parameters:
- DATA_W, 32, operand/immediate width
- ADR_W, 5, register address width
- CTRL_W, 16, width of the opaque EX/MEM/WB control bundle passed through
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decoded instruction present in ID
- id_rs  in  ADR_W  source register 1 address
- id_rt  in  ADR_W  source register 2 address
- id_dest  in  ADR_W  destination address (rd/rt already selected)
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_mem_read  in  1  instruction is a load
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_ctrl  in  CTRL_W  control bundle
- rf_adr1  out  ADR_W  register file read address 1 (= id_rs)
- rf_adr2  out  ADR_W  register file read address 2 (= id_rt)
- rf_data1  in  DATA_W  register file read data 1
- rf_data2  in  DATA_W  register file read data 2
- wb_reg_write  in  1  write-back enable (same signal driving the register file)
- wb_adr  in  ADR_W  write-back address
- wb_data  in  DATA_W  write-back data
- ex_hold  in  1  EX cannot accept (multi-cycle op)
- ex_flush  in  1  kill instruction entering EX (taken branch/jump)
- stall  out  1  freeze PC and IF/ID
- ex_valid, ex_rs, ex_rt, ex_dest, ex_mem_read, ex_imm, ex_ctrl  out  (widths as above)  registered ID/EX fields
- ex_rs_data  out  DATA_W  registered operand 1
- ex_rt_data  out  DATA_W  registered operand 2
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: every ex_* output and bubble_cnt go to 0 (ex_valid = 0, so a bubble).
  - stall is combinational, so it is 0 while ex_valid = 0.
  - rst has priority over all other inputs.
- rf_adr1/rf_adr2 are combinational copies of id_rs/id_rt.
- Bypass (combinational):
  - op1 = wb_data if wb_reg_write && wb_adr == id_rs, else rf_data1; op2 likewise for id_rt.
  - This is needed because the register file commits on the same edge that ID/EX captures.
  - Address 0 is not special-cased, matching the register file, which does not hardwire $0.
- Load-use hazard (combinational):
  - lu = id_valid && ex_valid && ex_mem_read && ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest)).
- stall = lu || ex_hold. It is not asserted by ex_flush.
- Per-edge priority, highest first:
  1. rst → clear everything.
  2. ex_flush → ex_valid <= 0, other fields don't-care (hold them). Flush overrides hold and lu.
  3. ex_hold → all ID/EX fields retain. Refresh exception:
     - If wb_reg_write && wb_adr == ex_rs, then ex_rs_data <= wb_data; likewise for ex_rt.
     - This keeps held operands current.
  4. lu → insert bubble: ex_valid <= 0, ex_mem_read <= 0, ctrl <= 0; bubble_cnt += 1, saturating at all-ones.
  5. Normal → capture id_* fields, op1 → ex_rs_data, op2 → ex_rt_data, ex_valid <= id_valid.
- Latency: one cycle ID → EX.
- A load-use stall lasts exactly one cycle; next cycle ex_valid = 0, so lu deasserts.
- ex_hold with lu simultaneous: hold wins; no bubble is counted, and lu re-evaluates after hold drops.
- id_valid = 0: normal capture loads a bubble; the hazard logic is ignored.
- Reset mid-stall: the next cycle is a clean bubble, stall = 0.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W, ADR_W, CTRL_W constants
  - ctrl_t packed struct (alu op, mem read/write, reg write, mem-to-reg, alu src)
  - id_ex_t struct bundling the registered fields
- One natural sub-module: hazard_bypass, purely combinational. It produces op1, op2 and lu.
- The stage keeps the register, priority logic and counter.

Test Plan:
- Reset: assert rst with id_valid=1 → next cycle ex_valid=0, bubble_cnt=0, stall=0.
- Bypass: id_rs=5, rf_data1=0x11, wb_reg_write=1, wb_adr=5, wb_data=0xAB → ex_rs_data=0xAB; with wb_adr=6 → 0x11.
- Load-use: `lw $8` then `add` using rs=8 → stall=1 for one cycle, bubble in EX, bubble_cnt=1, add enters EX a cycle later.
- Load-use with rt=8, id_uses_rt=0 → no stall; non-load producing $8 → no stall.
- Hold with refresh: ex_rt=3 held for 3 cycles, wb writes $3=0x55 in cycle 2 → fields unchanged except ex_rt_data=0x55, stall=1 throughout.
- Flush vs stall: ex_flush=1 with lu=1 and ex_hold=1 → ex_valid=0 next cycle, bubble_cnt unchanged.
- Saturation: force 2^CNT_W+3 bubbles → bubble_cnt=0xFFFF.
